// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single start/done port of the coprocessor matrix memory between
// the core sequencer and the host port. One transaction is in flight at a
// time; ties are broken round robin against the last owner. A watchdog aborts
// transactions whose memory never answers, and also bounds the wait for the
// memory to drop done after a transaction.

module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,

    input  logic          h_req,
    input  logic          h_wr,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic          h_err,

    output logic [DW-1:0] rdata,

    output logic          mem_start,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,

    output logic          busy,
    output logic          owner
);

    // Watchdog width covers 0..TIMEOUT; the abort fires on the cycle whose
    // increment would make the count equal TIMEOUT.
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_ONE  = CW'(1);
    localparam logic [CW-1:0] WD_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] wd_r, wd_s;

    logic          mem_start_r, mem_start_s;
    logic          mem_wr_r, mem_wr_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic [DW-1:0] rdata_r, rdata_s;
    logic          owner_r, owner_s;
    logic          busy_r, busy_s;
    logic          c_ack_r, c_ack_s;
    logic          c_err_r, c_err_s;
    logic          h_ack_r, h_ack_s;
    logic          h_err_r, h_err_s;

    // Core wins when it is the only requester, or on a tie when the host
    // held the port last.
    logic          grant_core_s;
    logic          grant_host_s;

    // Round-robin grant decision, evaluated only while idle.
    always_comb begin
        grant_core_s = 1'b0;
        grant_host_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (c_req && (!h_req || owner_r)) begin
                grant_core_s = 1'b1;
            end else if (h_req) begin
                grant_host_s = 1'b1;
            end else begin
                grant_core_s = 1'b0;
                grant_host_s = 1'b0;
            end
        end else begin
            grant_core_s = 1'b0;
            grant_host_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/ISSUE/RELEASE sequence.
    always_comb begin
        state_s     = state_r;
        wd_s        = wd_r;
        mem_start_s = mem_start_r;
        mem_wr_s    = mem_wr_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        rdata_s     = rdata_r;
        owner_s     = owner_r;
        c_ack_s     = 1'b0;
        c_err_s     = 1'b0;
        h_ack_s     = 1'b0;
        h_err_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (grant_core_s) begin
                    mem_wr_s    = c_wr;
                    mem_addr_s  = c_addr;
                    mem_wdata_s = c_wdata;
                    owner_s     = 1'b0;
                    mem_start_s = 1'b1;
                    wd_s        = WD_ZERO;
                    state_s     = ST_ISSUE;
                end else if (grant_host_s) begin
                    mem_wr_s    = h_wr;
                    mem_addr_s  = h_addr;
                    mem_wdata_s = h_wdata;
                    owner_s     = 1'b1;
                    mem_start_s = 1'b1;
                    wd_s        = WD_ZERO;
                    state_s     = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // A done level already present on entry counts as completion.
                if (mem_done) begin
                    if (!mem_wr_r) begin
                        rdata_s = mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    if (owner_r) begin
                        h_ack_s = 1'b1;
                    end else begin
                        c_ack_s = 1'b1;
                    end
                    mem_start_s = 1'b0;
                    wd_s        = WD_ZERO;
                    state_s     = ST_RELEASE;
                end else if (wd_r >= WD_LAST) begin
                    if (owner_r) begin
                        h_err_s = 1'b1;
                    end else begin
                        c_err_s = 1'b1;
                    end
                    mem_start_s = 1'b0;
                    wd_s        = WD_ZERO;
                    state_s     = ST_RELEASE;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end

            ST_RELEASE: begin
                // Hold off the next grant until the memory has dropped done,
                // so a stale done never completes the following transaction.
                if (!mem_done) begin
                    state_s = ST_IDLE;
                end else if (wd_r >= WD_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                mem_start_s = 1'b0;
                wd_s        = WD_ZERO;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, watchdog and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wd_r        <= WD_ZERO;
            mem_start_r <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
            owner_r     <= 1'b1;
            busy_r      <= 1'b0;
            c_ack_r     <= 1'b0;
            c_err_r     <= 1'b0;
            h_ack_r     <= 1'b0;
            h_err_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            wd_r        <= wd_s;
            mem_start_r <= mem_start_s;
            mem_wr_r    <= mem_wr_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rdata_r     <= rdata_s;
            owner_r     <= owner_s;
            busy_r      <= busy_s;
            c_ack_r     <= c_ack_s;
            c_err_r     <= c_err_s;
            h_ack_r     <= h_ack_s;
            h_err_r     <= h_err_s;
        end
    end

    assign mem_start = mem_start_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata     = rdata_r;
    assign owner     = owner_r;
    assign busy      = busy_r;
    assign c_ack     = c_ack_r;
    assign c_err     = c_err_r;
    assign h_ack     = h_ack_r;
    assign h_err     = h_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory with programmable
// latency answers the arbiter, and a reference copy of the memory contents
// plus a round-robin grant model supply every expected value.

module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_wr, h_req, h_wr;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          c_ack, c_err, h_ack, h_err;
    logic [DW-1:0] rdata;
    logic          mem_start, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_done;
    logic          busy, owner;

    int total = 0;
    int bad   = 0;

    // memory model
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    bit            loaded = 1'b0;
    int            mcnt = 0;
    int            lat = 2;
    bit            never_done = 1'b0;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [7:0] b;
        b = a[7:0];
        if (b == 8'h21) return 16'h00A5;
        return {b, ~b} ^ 16'h5A3C;
    endfunction

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err),
        .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_err(h_err),
        .rdata(rdata),
        .mem_start(mem_start), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // done rises lat cycles after start and falls together with start
    assign mem_done  = mem_start && !never_done && (mcnt >= lat);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (mem_start && mem_done && mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_start) mcnt <= mcnt + 1;
        else           mcnt <= 0;
    end

    // Drive one transaction from one requester and observe it until idle.
    task automatic issue(input bit host, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         output int n_ca, output int n_ce, output int n_ha, output int n_he,
                         output logic [DW-1:0] rd, output logic [AW-1:0] g_addr,
                         output logic [DW-1:0] g_wdata, output logic g_wr,
                         output logic g_owner, output int st, output int pulse_at,
                         output bit ok);
        bit fin;
        bit granted;
        fin = 0; granted = 0; ok = 0;
        n_ca = 0; n_ce = 0; n_ha = 0; n_he = 0;
        rd = '0; g_addr = '0; g_wdata = '0; g_wr = 1'b0; g_owner = 1'b0;
        st = 0; pulse_at = -1;
        if (host) begin
            h_req = 1'b1; h_wr = wr; h_addr = a; h_wdata = d;
        end else begin
            c_req = 1'b1; c_wr = wr; c_addr = a; c_wdata = d;
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n_ca += int'(c_ack); n_ce += int'(c_err);
            n_ha += int'(h_ack); n_he += int'(h_err);
            if (mem_start) st++;
            if (mem_start && !granted) begin
                granted = 1;
                g_addr = mem_addr; g_wdata = mem_wdata; g_wr = mem_wr; g_owner = owner;
                // later input changes must not reach the memory
                c_addr = AW'($urandom); c_wdata = DW'($urandom);
                h_addr = AW'($urandom); h_wdata = DW'($urandom);
            end
            if (!fin && (host ? (h_ack || h_err) : (c_ack || c_err))) begin
                fin = 1; pulse_at = st; rd = rdata;
                c_req = 1'b0; h_req = 1'b0;
            end else if (fin && !busy) begin
                ok = 1;
                break;
            end
        end
        c_req = 1'b0; h_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL reset_mem_start got=%b exp=0", mem_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL reset_owner got=%b exp=1", owner); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        total++; if ({mem_wr, mem_addr, mem_wdata} !== 25'd0) begin bad++; $display("FAIL reset_mem_regs got=%b/%h/%h exp=0", mem_wr, mem_addr, mem_wdata); end
        total++; if ({c_ack, c_err, h_ack, h_err} !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {c_ack, c_err, h_ack, h_err}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_core_write();
        int ca, ce, ha, he, st, pa; bit ok;
        logic [DW-1:0] rd, gw; logic [AW-1:0] ga; logic gwr, gown;
        lat = 3; never_done = 1'b0;
        issue(1'b0, 1'b1, 8'h12, 16'hBEEF, ca, ce, ha, he, rd, ga, gw, gwr, gown, st, pa, ok);
        ref_mem[8'h12] = 16'hBEEF;
        total++; if (!ok) begin bad++; $display("FAIL cw_complete got=%0d exp=1", ok); end
        total++; if (ga !== 8'h12) begin bad++; $display("FAIL cw_addr got=%h exp=12", ga); end
        total++; if (gw !== 16'hBEEF) begin bad++; $display("FAIL cw_wdata got=%h exp=beef", gw); end
        total++; if (gwr !== 1'b1) begin bad++; $display("FAIL cw_wr got=%b exp=1", gwr); end
        total++; if (ca != 1 || ce != 0) begin bad++; $display("FAIL cw_ack got=%0d/%0d exp=1/0", ca, ce); end
        total++; if (ha != 0 || he != 0) begin bad++; $display("FAIL cw_host_quiet got=%0d/%0d exp=0/0", ha, he); end
        total++; if (mem[8'h12] !== 16'hBEEF) begin bad++; $display("FAIL cw_mem got=%h exp=beef", mem[8'h12]); end
    endtask

    task automatic test_host_read();
        int ca, ce, ha, he, st, pa; bit ok;
        logic [DW-1:0] rd, gw; logic [AW-1:0] ga; logic gwr, gown;
        lat = 2;
        issue(1'b1, 1'b0, 8'h21, 16'h1234, ca, ce, ha, he, rd, ga, gw, gwr, gown, st, pa, ok);
        total++; if (ha != 1 || ca != 0 || ce != 0 || he != 0) begin bad++; $display("FAIL hr_pulses got=ca%0d ce%0d ha%0d he%0d exp=ha1", ca, ce, ha, he); end
        total++; if (rd !== 16'h00A5) begin bad++; $display("FAIL hr_rdata_at_ack got=%h exp=00a5", rd); end
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL hr_owner got=%b exp=1", owner); end
        repeat (3) @(negedge clk);
        total++; if (rdata !== 16'h00A5) begin bad++; $display("FAIL hr_rdata_held got=%h exp=00a5", rdata); end
    endtask

    task automatic test_contention();
        logic [AW-1:0] ac, ah;
        logic grants [0:3];
        int ng, nack;
        logic prev, last, expw;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lat = $urandom_range(0, 3);
        ac = AW'($urandom); ah = AW'($urandom);
        c_req = 1'b1; c_wr = 1'b0; c_addr = ac; c_wdata = '0;
        h_req = 1'b1; h_wr = 1'b0; h_addr = ah; h_wdata = '0;
        ng = 0; nack = 0; prev = 1'b0;
        for (int k = 0; k < 200 && nack < 4; k++) begin
            @(negedge clk);
            if (mem_start && !prev && ng < 4) begin grants[ng] = owner; ng++; end
            prev = mem_start;
            if (c_ack) begin
                nack++;
                total++; if (rdata !== ref_mem[ac]) begin bad++; $display("FAIL cont_core_rdata got=%h exp=%h", rdata, ref_mem[ac]); end
            end
            if (h_ack) begin
                nack++;
                total++; if (rdata !== ref_mem[ah]) begin bad++; $display("FAIL cont_host_rdata got=%h exp=%h", rdata, ref_mem[ah]); end
            end
        end
        c_req = 1'b0; h_req = 1'b0;
        total++; if (ng != 4) begin bad++; $display("FAIL cont_grant_count got=%0d exp=4", ng); end
        // both always requesting: every grant goes to the one that did not hold it last
        last = 1'b1;
        for (int i = 0; i < ng; i++) begin
            expw = ~last;
            total++; if (grants[i] !== expw) begin bad++; $display("FAIL cont_order%0d got=%b exp=%b", i, grants[i], expw); end
            last = expw;
        end
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    endtask

    task automatic test_timeout();
        int ca, ce, ha, he, st, pa; bit ok;
        logic [DW-1:0] rd, gw; logic [AW-1:0] ga; logic gwr, gown;
        never_done = 1'b1;
        issue(1'b0, 1'b0, 8'h40, 16'h0000, ca, ce, ha, he, rd, ga, gw, gwr, gown, st, pa, ok);
        never_done = 1'b0;
        total++; if (ce != 1 || ca != 0) begin bad++; $display("FAIL to_pulses got=err%0d ack%0d exp=err1 ack0", ce, ca); end
        total++; if (st != TO) begin bad++; $display("FAIL to_start_cycles got=%0d exp=%0d", st, TO); end
        total++; if (pa != TO) begin bad++; $display("FAIL to_err_position got=%0d exp=%0d", pa, TO); end
        total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL to_back_idle got=%0d/%b exp=1/0", ok, busy); end
    endtask

    task automatic test_reset_mid();
        int ca, ce, ha, he, st, pa; bit ok; bit seen;
        logic [DW-1:0] rd, gw; logic [AW-1:0] ga; logic gwr, gown;
        int acks;
        never_done = 1'b1; seen = 0; acks = 0;
        c_req = 1'b1; c_wr = 1'b0; c_addr = 8'h33; c_wdata = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = mem_start;
        end
        total++; if (!seen) begin bad++; $display("FAIL rm_grant got=0 exp=1"); end
        repeat (2) begin @(negedge clk); acks += int'(c_ack); end
        reset = 1'b1;
        @(negedge clk);
        acks += int'(c_ack);
        reset = 1'b0; c_req = 1'b0; never_done = 1'b0;
        total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL rm_start got=%b exp=0", mem_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (acks != 0) begin bad++; $display("FAIL rm_no_ack got=%0d exp=0", acks); end
        lat = 2;
        issue(1'b0, 1'b0, 8'h33, 16'h0000, ca, ce, ha, he, rd, ga, gw, gwr, gown, st, pa, ok);
        total++; if (!ok || ca != 1 || rd !== ref_mem[8'h33]) begin bad++; $display("FAIL rm_reissue got=ok%0d ack%0d rd=%h exp=ok1 ack1 rd=%h", ok, ca, rd, ref_mem[8'h33]); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [0:5];
        int rises [0:5];
        int nr, idx, cyc;
        bit pending, prev;
        lat = 1;
        for (int i = 0; i < 6; i++) addrs[i] = AW'($urandom);
        nr = 0; idx = 0; cyc = 0; pending = 0; prev = 0;
        c_req = 1'b1; c_wr = 1'b0; c_addr = addrs[0];
        for (int k = 0; k < 200 && idx < 6; k++) begin
            @(negedge clk);
            cyc++;
            if (mem_start && !prev && nr < 6) begin rises[nr] = cyc; nr++; end
            prev = mem_start;
            if (c_ack) begin
                total++; if (rdata !== ref_mem[addrs[idx]]) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", idx, rdata, ref_mem[addrs[idx]]); end
                idx++;
                c_req = 1'b0;
                pending = (idx < 6);
            end else if (pending) begin
                c_req = 1'b1; c_addr = addrs[idx];
                pending = 0;
            end
        end
        c_req = 1'b0;
        total++; if (idx != 6 || nr != 6) begin bad++; $display("FAIL b2b_count got=%0d/%0d exp=6/6", idx, nr); end
        for (int i = 1; i < nr; i++) begin
            total++; if (rises[i] - rises[i-1] != 4) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=4", i, rises[i] - rises[i-1]); end
        end
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    endtask

    task automatic test_random();
        int ca, ce, ha, he, st, pa; bit ok;
        logic [DW-1:0] rd, gw, d; logic [AW-1:0] ga, a; logic gwr, gown;
        bit host, wr;
        int exp_ca, exp_ha;
        for (int t = 0; t < 24; t++) begin
            host = 1'($urandom); wr = 1'($urandom);
            a = AW'($urandom_range(0, 15)); d = DW'($urandom);
            lat = $urandom_range(0, 4);
            issue(host, wr, a, d, ca, ce, ha, he, rd, ga, gw, gwr, gown, st, pa, ok);
            exp_ca = host ? 0 : 1; exp_ha = host ? 1 : 0;
            total++; if (!ok || ca != exp_ca || ha != exp_ha || ce != 0 || he != 0) begin bad++; $display("FAIL rnd%0d_pulses got=ok%0d ca%0d ha%0d ce%0d he%0d exp=ca%0d ha%0d", t, ok, ca, ha, ce, he, exp_ca, exp_ha); end
            total++; if (ga !== a || gwr !== wr || gown !== host) begin bad++; $display("FAIL rnd%0d_grant got=%h/%b/%b exp=%h/%b/%b", t, ga, gwr, gown, a, wr, host); end
            if (wr) begin
                total++; if (gw !== d) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", t, gw, d); end
                ref_mem[a] = d;
            end else begin
                total++; if (rd !== ref_mem[a]) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, rd, ref_mem[a]); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_core_write();
        test_host_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single port of the coprocessor matrix memory (8-bit address, 16-bit data, level `start`/`done` handshake) between two requesters: the core sequencer (load / execute / write-back FSM) and a host read/write port. It sits between both requesters and `memory_mod`. It grants one transaction at a time with round-robin fairness, drives the memory start/done handshake, returns read data, and aborts hung transactions with a watchdog.

## Interface
- `AW`, 8, address width
- `DW`, 16, data width
- `TIMEOUT`, 255, max cycles `mem_start` stays high without `mem_done` before abort (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `c_req`  in  1  core request; held until `c_ack` or `c_err`
- `c_wr`  in  1  core: 1 = write, 0 = read
- `c_addr`  in  AW  core address
- `c_wdata`  in  DW  core write data
- `c_ack`  out  1  one-cycle pulse, core transaction done
- `c_err`  out  1  one-cycle pulse, core transaction timed out
- `h_req`, `h_wr`, `h_addr`, `h_wdata`, `h_ack`, `h_err`  same as the core set, for the host
- `rdata`  out  DW  read data; valid in the cycle of the owner's ack, held until the next capture
- `mem_start`  out  1  memory start level
- `mem_wr`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data
- `mem_done`  in  1  memory done level
- `busy`  out  1  high when the arbiter is not in IDLE
- `owner`  out  1  0 = core, 1 = host; the last or current grant

## Operation
- States: IDLE, ISSUE, RELEASE. All outputs are registered.
- IDLE
  - If neither request is asserted, stay.
  - If only one request is asserted, grant it.
  - If both are asserted, grant the requester that is not `owner` (round robin).
  - On grant: latch the winner's `wr`/`addr`/`wdata` into the `mem_*` registers, set `owner`, set `mem_start`=1, clear the watchdog counter, go to ISSUE.
- ISSUE
  - Increment the watchdog each cycle.
  - On `mem_done`=1: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), pulse the owner's ack, set `mem_start`=0, go to RELEASE.
  - Else, if the counter reaches TIMEOUT: pulse the owner's err (no ack), set `mem_start`=0, go to RELEASE.
- RELEASE
  - Wait for `mem_done`=0, then go to IDLE.
  - The same watchdog applies (counter cleared on entry). On expiry, go to IDLE without any pulse.
- Request inputs are sampled only in IDLE. Changes to `addr`/`wdata` after grant have no effect.
- A requester must drop `req` the cycle after its ack or err. RELEASE lasts at least one cycle, so a held-over req cannot be re-granted.
- `mem_wr`/`mem_addr`/`mem_wdata` stay stable from grant until the next grant.
- At most one of `c_ack`, `c_err`, `h_ack`, `h_err` is high in any cycle.

## Timing
- Reset values: state IDLE; `mem_start`, `mem_wr`, `c_ack`, `c_err`, `h_ack`, `h_err`, `busy` = 0; `mem_addr`, `mem_wdata`, `rdata` = 0; `owner` = 1, so the core wins the first tie.
- Reset mid-transaction: `mem_start` drops the next edge and any pending ack is discarded. The requester re-issues.
- Latency:
  - `req` high at edge N (in IDLE) gives `mem_start`=1 and `busy`=1 after edge N.
  - `mem_done` sampled high at edge M gives the ack pulse and `mem_start`=0 after edge M.
  - If `mem_done` is sampled low at edge M+1, the arbiter is in IDLE after M+1.
  - The next grant is sampled at M+2. Minimum spacing between two `mem_start` rises is 3 cycles plus memory latency.
- Watchdog: err is asserted after TIMEOUT cycles of `mem_start` without `mem_done`.
- `mem_done` already high when entering ISSUE (stale) counts as completion. Memory must drop `done` after `start` falls, which RELEASE enforces.

## Test plan
- Core write: `c_req`=1, `c_wr`=1, `c_addr`=0x12, `c_wdata`=0xBEEF; model `done` after 3 cycles → `mem_addr`=0x12, `mem_wdata`=0xBEEF, `mem_wr`=1, exactly one `c_ack` pulse, no `h_*` activity.
- Host read: `mem_rdata`=0x00A5 at 0x21 → `h_ack` pulse, `rdata`=0x00A5 in the same cycle, `owner`=1, `rdata` held afterwards.
- Contention: `c_req` and `h_req` both held continuously for 4 transactions, starting from reset → grants in order core, host, core, host.
- Timeout: TIMEOUT=8, memory never asserts done → `c_err` pulses on the 8th cycle of `mem_start`, no `c_ack`, arbiter back in IDLE once `mem_done`=0.
- Reset mid-ISSUE: assert `reset` 2 cycles after grant → after the next edge `mem_start`=0, `busy`=0, no ack; a later request completes normally.
- Back-to-back core reads with memory latency 1 → `mem_start` rises every 4 cycles; `rdata` matches each returned word.
